// File: rtl/branch_predict_fetch.sv
// Fetch PC owner: predicts the next PC from the BTB, queues predictions until EX resolves them,
// and issues BTB updates. A wrong prediction redirects the PC and flushes the front end.
package dp_types_pkg;
  typedef enum logic [1:0] {
    NH = 2'b00,
    NS = 2'b01,
    TS = 2'b10,
    TH = 2'b11
  } btb_state_t;
endpackage

module branch_predict_fetch
  import dp_types_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        halt,
  output logic [31:0] pc,
  output logic        fetch_stall,
  output logic [7:0]  btb_rsel,
  input  logic [1:0]  btb_rstate,
  input  logic [31:0] btb_rtarget,
  output logic        pred_taken,
  input  logic        ex_adv,
  input  logic        ex_branch,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  output logic        flush,
  output logic        btb_wen,
  output logic [7:0]  btb_wsel,
  output logic [1:0]  btb_wstate,
  output logic [31:0] btb_wtarget,
  output logic        btb_phit,
  output logic        proto_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [1:0]  state;
    logic [31:0] target;
  } qent_t;

  qent_t         r_q [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [31:0]   r_pc;
  logic          r_halted;
  logic          r_flush;
  logic          r_wen;
  logic [7:0]    r_wsel;
  logic [1:0]    r_wstate;
  logic [31:0]   r_wtarget;
  logic          r_phit;
  logic          r_proto_err;

  qent_t         w_head;
  logic          w_pred_taken;
  logic [31:0]   w_npc;
  logic          w_pop;
  logic          w_full;
  logic          w_stall;
  logic          w_push;
  logic          w_mis;
  logic          w_upd;
  logic [AW:0]   w_count_nxt;

  assign w_head       = r_q[r_head];
  assign w_pred_taken = btb_rstate[1];
  assign w_npc        = w_pred_taken ? btb_rtarget : (r_pc + 32'd4);
  assign w_pop        = ex_adv & (r_count != '0);
  assign w_full       = (r_count == (AW+1)'(DEPTH));
  // A retiring entry frees a slot in the same cycle, so a full queue can still accept.
  assign w_stall      = w_full & ~w_pop;
  assign w_upd        = w_pop & ex_branch;
  assign w_mis        = w_upd & ((ex_taken != w_head.pred_taken) |
                                 (ex_taken & w_head.pred_taken & (ex_target != w_head.target)));
  assign w_push       = ihit & ~w_stall & ~r_halted & ~w_mis;
  assign w_count_nxt  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc        <= PC_RESET;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_halted    <= 1'b0;
      r_flush     <= 1'b0;
      r_wen       <= 1'b0;
      r_wsel      <= 8'h00;
      r_wstate    <= NS;
      r_wtarget   <= 32'h0;
      r_phit      <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_flush <= w_mis;
      r_wen   <= w_upd;
      if (w_upd) begin
        r_wsel    <= w_head.pc[9:2];
        r_wstate  <= w_head.state;
        r_phit    <= (ex_taken == w_head.pred_taken);
        r_wtarget <= ex_taken ? ex_target : w_head.target;
      end
      if (ex_adv && (r_count == '0)) begin
        r_proto_err <= 1'b1;
      end
      if (halt) begin
        r_halted <= 1'b1;
      end
      if (w_mis) begin
        r_pc    <= ex_taken ? ex_target : (w_head.pc + 32'd4);
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_pc   <= w_npc;
          r_tail <= r_tail + AW'(1);
        end
        if (w_pop) begin
          r_head <= r_head + AW'(1);
        end
        r_count <= w_count_nxt;
      end
    end
  end

  // Entry payload needs no reset: r_count gates every read.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_q[r_tail] <= '{pc: r_pc, pred_taken: w_pred_taken, state: btb_rstate, target: btb_rtarget};
    end
  end

  assign pc          = r_pc;
  assign fetch_stall = w_stall;
  assign btb_rsel    = r_pc[9:2];
  assign pred_taken  = w_pred_taken;
  assign flush       = r_flush;
  assign btb_wen     = r_wen;
  assign btb_wsel    = r_wsel;
  assign btb_wstate  = r_wstate;
  assign btb_wtarget = r_wtarget;
  assign btb_phit    = r_phit;
  assign proto_err   = r_proto_err;

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Directed bench for branch_predict_fetch with a hand-driven BTB read port.
module tb_branch_predict_fetch;

  logic        CLK;
  logic        RST;
  logic        ihit;
  logic        halt;
  logic [31:0] pc;
  logic        fetch_stall;
  logic [7:0]  btb_rsel;
  logic [1:0]  btb_rstate;
  logic [31:0] btb_rtarget;
  logic        pred_taken;
  logic        ex_adv;
  logic        ex_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        flush;
  logic        btb_wen;
  logic [7:0]  btb_wsel;
  logic [1:0]  btb_wstate;
  logic [31:0] btb_wtarget;
  logic        btb_phit;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  branch_predict_fetch #(.PC_RESET(32'h0000_0040), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .halt(halt), .pc(pc), .fetch_stall(fetch_stall),
    .btb_rsel(btb_rsel), .btb_rstate(btb_rstate), .btb_rtarget(btb_rtarget),
    .pred_taken(pred_taken), .ex_adv(ex_adv), .ex_branch(ex_branch), .ex_taken(ex_taken),
    .ex_target(ex_target), .flush(flush), .btb_wen(btb_wen), .btb_wsel(btb_wsel),
    .btb_wstate(btb_wstate), .btb_wtarget(btb_wtarget), .btb_phit(btb_phit),
    .proto_err(proto_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".pc"},      pc,          32'h40);
    chk({tag, ".flush"},   32'(flush),       32'd0);
    chk({tag, ".wen"},     32'(btb_wen),     32'd0);
    chk({tag, ".wsel"},    32'(btb_wsel),    32'h0);
    chk({tag, ".wstate"},  32'(btb_wstate),  32'd1);
    chk({tag, ".wtarget"}, btb_wtarget, 32'h0);
    chk({tag, ".perr"},    32'(proto_err),   32'd0);
    chk({tag, ".stall"},   32'(fetch_stall), 32'd0);
  endtask

  logic [7:0] exp_wsel [4];

  initial begin
    RST = 1'b1; ihit = 1'b0; halt = 1'b0;
    btb_rstate = 2'b01; btb_rtarget = 32'h0;
    ex_adv = 1'b0; ex_branch = 1'b0; ex_taken = 1'b0; ex_target = 32'h0;
    exp_wsel[0] = 8'h26; exp_wsel[1] = 8'h27; exp_wsel[2] = 8'h28; exp_wsel[3] = 8'h29;
    repeat (2) tick();
    RST = 1'b0;
    #1;
    chk_reset_outputs("rst0");
    chk("rst0.rsel", 32'(btb_rsel), 32'h10);

    // Sequential fetch, BTB says NS
    ihit = 1'b1;
    #1;
    chk("seq.pred", 32'(pred_taken), 32'd0);
    tick(); chk("seq.pc1", pc, 32'h44);
    tick(); chk("seq.pc2", pc, 32'h48);
    tick(); chk("seq.pc3", pc, 32'h4C);
    chk("seq.stall", 32'(fetch_stall), 32'd0);
    chk("seq.flush", 32'(flush), 32'd0);
    ihit = 1'b0;

    // Asynchronous reset with three entries queued
    RST = 1'b1;
    #1;
    chk("rst1.pc", pc, 32'h40);
    RST = 1'b0;

    // Predicted taken, resolved correctly
    btb_rstate = 2'b11; btb_rtarget = 32'h200; ihit = 1'b1;
    #1;
    chk("th.pred", 32'(pred_taken), 32'd1);
    tick();
    ihit = 1'b0;
    chk("th.pc", pc, 32'h200);
    chk("th.rsel", 32'(btb_rsel), 32'h80);
    ex_adv = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h200;
    tick();
    ex_adv = 1'b0;
    chk("th.flush",   32'(flush),      32'd0);
    chk("th.wen",     32'(btb_wen),    32'd1);
    chk("th.wsel",    32'(btb_wsel),   32'h10);
    chk("th.wstate",  32'(btb_wstate), 32'd3);
    chk("th.phit",    32'(btb_phit),   32'd1);
    chk("th.wtarget", btb_wtarget,     32'h200);
    chk("th.pc2",     pc,              32'h200);
    tick();
    chk("th.wen_off", 32'(btb_wen), 32'd0);

    // Predicted not-taken at 0x80, resolved taken to 0x300
    ihit = 1'b1; btb_rstate = 2'b11; btb_rtarget = 32'h80;
    tick(); chk("ns.pc80", pc, 32'h80);
    btb_rstate = 2'b01; btb_rtarget = 32'h0;
    tick(); chk("ns.pc84", pc, 32'h84);
    ihit = 1'b0; ex_adv = 1'b1; ex_branch = 1'b0;
    tick();
    chk("ns.nb_wen", 32'(btb_wen), 32'd0);
    chk("ns.nb_pc", pc, 32'h84);
    ihit = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h300;
    tick();
    ihit = 1'b0; ex_adv = 1'b0;
    chk("ns.pc",      pc,              32'h300);
    chk("ns.flush",   32'(flush),      32'd1);
    chk("ns.wen",     32'(btb_wen),    32'd1);
    chk("ns.wsel",    32'(btb_wsel),   32'h20);
    chk("ns.wstate",  32'(btb_wstate), 32'd1);
    chk("ns.phit",    32'(btb_phit),   32'd0);
    chk("ns.wtarget", btb_wtarget,     32'h300);
    tick();
    chk("ns.flush_off", 32'(flush),   32'd0);
    chk("ns.wen_off",   32'(btb_wen), 32'd0);
    chk("ns.pc_hold",   pc,           32'h300);

    // Predicted taken (TS/0x500) at 0x90, resolved not taken
    ihit = 1'b1; btb_rstate = 2'b10; btb_rtarget = 32'h90;
    tick(); chk("ts.pc90", pc, 32'h90);
    btb_rtarget = 32'h500;
    tick(); chk("ts.pc500", pc, 32'h500);
    ihit = 1'b0; ex_adv = 1'b1; ex_branch = 1'b1; ex_taken = 1'b1; ex_target = 32'h90;
    tick();
    chk("ts.ok_flush",   32'(flush),      32'd0);
    chk("ts.ok_wsel",    32'(btb_wsel),   32'hC0);
    chk("ts.ok_wstate",  32'(btb_wstate), 32'd2);
    chk("ts.ok_phit",    32'(btb_phit),   32'd1);
    chk("ts.ok_wtarget", btb_wtarget,     32'h90);
    ex_taken = 1'b0; ex_target = 32'h0;
    tick();
    ex_adv = 1'b0;
    chk("ts.pc",      pc,              32'h94);
    chk("ts.flush",   32'(flush),      32'd1);
    chk("ts.wsel",    32'(btb_wsel),   32'h24);
    chk("ts.wstate",  32'(btb_wstate), 32'd2);
    chk("ts.phit",    32'(btb_phit),   32'd0);
    chk("ts.wtarget", btb_wtarget,     32'h500);
    tick();
    chk("ts.flush_off", 32'(flush), 32'd0);

    // Fill the queue, stall, then push while popping
    btb_rstate = 2'b01; btb_rtarget = 32'h0; ihit = 1'b1;
    repeat (4) tick();
    chk("full.pc",    pc,               32'hA4);
    chk("full.stall", 32'(fetch_stall), 32'd1);
    repeat (2) tick();
    chk("full.pc_frozen", pc, 32'hA4);
    ex_adv = 1'b1; ex_branch = 1'b0;
    #1;
    chk("full.stall_pop", 32'(fetch_stall), 32'd0);
    tick();
    ex_adv = 1'b0;
    #1;
    chk("full.pc_push", pc,               32'hA8);
    chk("full.stall2",  32'(fetch_stall), 32'd1);
    ihit = 1'b0; ex_adv = 1'b1; ex_branch = 1'b1; ex_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("wrap.wsel%0d", i), 32'(btb_wsel), 32'(exp_wsel[i]));
      chk($sformatf("wrap.wen%0d", i),  32'(btb_wen),  32'd1);
      chk($sformatf("wrap.phit%0d", i), 32'(btb_phit), 32'd1);
    end
    chk("wrap.wtarget", btb_wtarget, 32'h0);
    chk("wrap.flush",   32'(flush),  32'd0);

    // ex_adv with an empty queue
    ex_taken = 1'b1; ex_target = 32'h700;
    tick();
    ex_adv = 1'b0;
    chk("perr.set",   32'(proto_err), 32'd1);
    chk("perr.wen",   32'(btb_wen),   32'd0);
    chk("perr.pc",    pc,             32'hA8);
    chk("perr.flush", 32'(flush),     32'd0);
    tick();
    chk("perr.sticky", 32'(proto_err), 32'd1);

    // Halt with two entries queued
    ihit = 1'b1; ex_taken = 1'b0; ex_target = 32'h0;
    tick(); tick();
    chk("halt.pc_pre", pc, 32'hB0);
    ihit = 1'b0; halt = 1'b1;
    tick();
    halt = 1'b0; ihit = 1'b1;
    tick(); tick();
    chk("halt.pc_frozen", pc, 32'hB0);
    ex_adv = 1'b1; ex_branch = 1'b1;
    tick();
    chk("halt.wen1",  32'(btb_wen),  32'd1);
    chk("halt.wsel1", 32'(btb_wsel), 32'h2A);
    chk("halt.pc1",   pc,            32'hB0);
    tick();
    chk("halt.wen2",  32'(btb_wen),  32'd1);
    chk("halt.wsel2", 32'(btb_wsel), 32'h2B);
    ex_adv = 1'b0; ihit = 1'b0;

    // Asynchronous reset while a BTB write is in progress
    RST = 1'b1;
    #1;
    chk_reset_outputs("rst2");
    RST = 1'b0;
    ihit = 1'b1;
    tick();
    chk("rst2.unhalted", pc, 32'h44);
    ihit = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_fetch.md
Name: branch_predict_fetch

Overview:
- Fetch-side consumer and update producer for the branch target buffer.
- Owns the PC register and reads the BTB every cycle to predict the next PC.
- Tracks in-flight predictions in a small in-order queue until the EX stage resolves them.
- On resolution it drives the BTB write port (wen/wsel/wdat/phit) and, on a misprediction, redirects the PC and flushes the front end.

Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 4, in-flight prediction queue entries (power of two, >=2).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- ihit  input  1  I-cache hit; the fetch at pc completes this cycle.
- halt  input  1  halt resolved in EX; freezes PC until reset.
- pc  output  32  current fetch address.
- fetch_stall  output  1  queue full; the fetch at pc is not accepted.
- btb_rsel  output  8  BTB read index = pc[9:2].
- btb_rstate  input  2  BTB read state.
- btb_rtarget  input  32  BTB read target.
- pred_taken  output  1  prediction for the instruction at pc.
- ex_adv  input  1  the oldest in-flight instruction leaves EX this cycle.
- ex_branch  input  1  that instruction is a conditional branch.
- ex_taken  input  1  actual branch outcome.
- ex_target  input  32  actual branch target.
- flush  output  1  one-cycle front-end flush pulse.
- btb_wen  output  1  BTB write enable.
- btb_wsel  output  8  BTB write index.
- btb_wstate  output  2  current (pre-update) state of the entry being written.
- btb_wtarget  output  32  target to store.
- btb_phit  output  1  1 = prediction correct.
- proto_err  output  1  sticky; set if ex_adv arrives while the queue is empty.

Behaviour:
- State encoding (dp_types_pkg): NH=00, NS=01, TS=10, TH=11. The prediction is taken iff state[1]=1.
- Combinational prediction: pred_taken = btb_rstate[1]; predicted npc = pred_taken ? btb_rtarget : pc+4.
- Reset values: pc=PC_RESET; queue empty; flush=0; btb_wen=0; btb_wsel=0; btb_wstate=NS; btb_wtarget=0; proto_err=0; halted=0.
- Queue entry: {pc, pred_taken, btb_rstate, btb_rtarget}. Circular buffer with head/tail pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
- push = ihit & ~fetch_stall & ~halted & ~mispredict.
- fetch_stall = (count==DEPTH) & ~pop.
- pop = ex_adv & (count!=0).
- On push: write the entry at tail; pc <= predicted npc.
- mispredict = pop & ex_branch & ((ex_taken != head.pred_taken) | (ex_taken & head.pred_taken & ex_target != head.target)).
- Mispredict priority is above everything except reset:
  - pc <= ex_taken ? ex_target : head.pc+4.
  - The queue is cleared (count=0, head=tail=0).
  - flush=1 in the next cycle only.
  - Any same-cycle push is dropped.
- BTB update: pop & ex_branch registers a write that is visible in the next cycle, so the BTB's negedge write lands mid-cycle.
  - btb_wen=1; btb_wsel=head.pc[9:2]; btb_wstate=head.state; btb_phit = (ex_taken==head.pred_taken).
  - btb_wtarget = ex_taken ? ex_target : head.target.
  - btb_wen returns to 0 in the following cycle unless another update occurs.
- A non-branch pop retires the entry with no BTB write.
- Full and pop in the same cycle: push is allowed; count is unchanged.
- ex_adv with an empty queue: no pop, no write; proto_err <= 1.
- halt: halted <= 1. The PC holds, no further pushes, pending pops are still processed. A mispredict in the same cycle still loads pc and then holds.
- RST asserted mid-operation: all state returns to its reset values immediately (asynchronously), including any in-progress BTB write (btb_wen=0).

Test Plan:
- Reset with PC_RESET=0x40, BTB returns NS, ihit held 3 cycles -> pc 0x40, 0x44, 0x48, 0x4C; count=3; pred_taken=0; no flush.
- BTB returns TH/target 0x200 at pc 0x40 with ihit -> next pc=0x200; later pop with ex_branch=1, ex_taken=1, ex_target=0x200 -> no flush; next cycle btb_wen=1, wsel=0x10, wstate=TH, phit=1, wtarget=0x200.
- Predicted not-taken (NS) at 0x80, resolved taken to 0x300 -> pc=0x300 next cycle; flush pulses 1 cycle; count=0; btb_wen=1, wstate=NS, phit=0, wtarget=0x300.
- Predicted taken (TS, target 0x500) at 0x90, resolved not-taken -> pc=0x94; flush=1; phit=0; wtarget=0x500.
- ihit held, ex_adv=0 for 6 cycles with DEPTH=4 -> fetch_stall=1 after 4 pushes with pc frozen; one ex_adv (non-branch) -> a push occurs that cycle, count stays 4, pointers wrap correctly.
- ex_adv with empty queue -> proto_err=1 and sticky, no btb_wen; halt with 2 entries queued -> pc frozen, two pops still produce their BTB writes; RST pulse -> all outputs at their reset values.
